systolic_result_drain: RTL and testbench

Reader end of the systolic processor output. It starts on a pulse marking the first skewed A/B input cycle and waits the fixed fill/compute latency of the array. It then snapshots the flat C bus and streams the SIZE*SIZE results row-major over a valid/ready interface. The snapshot frees the array to be reset and reloaded while the drain is still streaming.

---
 rtl/systolic_result_drain_pkg.sv | 28 ++
 rtl/systolic_drain_serializer.sv | 56 +++++
 rtl/systolic_result_drain.sv | 116 +++++++++++
 tb/tb_systolic_result_drain.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic array result drain: derived widths,
// fill/compute latency, FSM state encoding and flat-index to row/col split.
package systolic_result_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } drain_state_e;

    function automatic int calc_o_bits(input int size, input int i_bits);
        return 2 * i_bits + $clog2(size);
    endfunction

    function automatic int calc_compute_cycles(input int size);
        return 3 * size - 1;
    endfunction

    function automatic int idx_row(input int idx, input int size);
        return idx / size;
    endfunction

    function automatic int idx_col(input int idx, input int size);
        return idx % size;
    endfunction

endpackage

// File: rtl/systolic_drain_serializer.sv
// Snapshot of the flat C bus plus a row-major read pointer; outputs are
// forced to zero whenever the drain is not presenting an element.
module systolic_drain_serializer
    import systolic_result_drain_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int O_BITS   = 19,
    parameter int IDX_BITS = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_load,
    input  logic                          i_advance,
    input  logic                          i_enable,
    input  logic [SIZE*SIZE*O_BITS-1:0]   i_bus,
    output logic [O_BITS-1:0]             o_data,
    output logic [IDX_BITS-1:0]           o_row,
    output logic [IDX_BITS-1:0]           o_col,
    output logic                          o_last
);

    localparam int N        = SIZE * SIZE;
    localparam int PTR_BITS = $clog2(N);
    localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(N - 1);

    logic [N*O_BITS-1:0]  r_snap;
    logic [PTR_BITS-1:0]  r_index;
    logic [O_BITS-1:0]    w_elem;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_snap  <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_snap  <= i_bus;
            r_index <= '0;
        end else if (i_advance && (r_index != LAST_IDX)) begin
            r_index <= r_index + 1'b1;
        end
    end

    always_comb begin
        w_elem = r_snap[O_BITS*int'(r_index) +: O_BITS];
        o_data = '0;
        o_row  = '0;
        o_col  = '0;
        o_last = 1'b0;
        if (i_enable) begin
            o_data = w_elem;
            o_row  = IDX_BITS'(idx_row(int'(r_index), SIZE));
            o_col  = IDX_BITS'(idx_col(int'(r_index), SIZE));
            o_last = (r_index == LAST_IDX);
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Reader end of the systolic array: waits the fill/compute latency after a
// start pulse, snapshots the C bus and streams it row-major over valid/ready.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int SIZE           = 8,
    parameter int I_BITS         = 8,
    parameter int O_BITS         = calc_o_bits(SIZE, I_BITS),
    parameter int COMPUTE_CYCLES = calc_compute_cycles(SIZE),
    parameter int IDX_BITS       = $clog2(SIZE)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [SIZE*SIZE*O_BITS-1:0]   i_c_full,
    output logic                          o_busy,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [O_BITS-1:0]             o_data,
    output logic [IDX_BITS-1:0]           o_row,
    output logic [IDX_BITS-1:0]           o_col,
    output logic                          o_last,
    output logic                          o_done,
    output logic                          o_start_drop
);

    localparam int CNT_BITS = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(COMPUTE_CYCLES - 1);

    drain_state_e          r_state;
    drain_state_e          w_next;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_start_drop;
    logic                  w_load;
    logic                  w_valid;
    logic                  w_fire;
    logic                  w_last;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) w_next = ST_SEND;
            end
            ST_SEND: begin
                w_valid = 1'b1;
                if (i_ready && w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_load  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_fire  = w_valid && i_ready;
    assign o_valid = w_valid;

    // Counter reaches zero on edge t0+COMPUTE_CYCLES-1, so capture lands on t0+COMPUTE_CYCLES.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_start_drop <= 1'b0;
        end else begin
            r_start_drop <= i_start && (r_state != ST_IDLE);
        end
    end

    assign o_start_drop = r_start_drop;

    systolic_drain_serializer #(
        .SIZE     (SIZE),
        .O_BITS   (O_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_advance (w_fire),
        .i_enable  (w_valid),
        .i_bus     (i_c_full),
        .o_data    (o_data),
        .o_row     (o_row),
        .o_col     (o_col),
        .o_last    (w_last)
    );

    assign o_last = w_last;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes expected words,
// negedge monitors pop and compare on every handshake.
module tb_systolic_result_drain;

    localparam int S8  = 8;
    localparam int OB8 = 19;
    localparam int CC8 = 23;
    localparam int N8  = 64;
    localparam int S4  = 4;
    localparam int OB4 = 18;
    localparam int CC4 = 11;
    localparam int N4  = 16;

    typedef struct {
        longint data;
        int     row;
        int     col;
        bit     last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start, ready;
    logic [N8*OB8-1:0]    bus;
    logic                 busy, valid, last, done, drop;
    logic [OB8-1:0]       data;
    logic [2:0]           row, col;

    logic                 start4;
    logic                 ready4;
    logic [N4*OB4-1:0]    bus4;
    logic                 busy4, valid4, last4, done4, drop4;
    logic [OB4-1:0]       data4;
    logic [1:0]           row4, col4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q[$];
    exp_t q4[$];
    logic [OB8-1:0] exp_vals[N8];

    int  hs_count = 0, drop_seen = 0, exp_drops = 0;
    int  first_valid_cyc = -1, done_cyc = -1;
    bit  done_seen = 0, pending_done = 0, held = 0;
    logic [OB8-1:0] h_data;
    logic [2:0]     h_row, h_col;
    logic           h_last;
    int  ready_mode = 0, pcnt = 0;
    int  hs4 = 0;
    bit  pending4 = 0, done4_seen = 0;

    systolic_result_drain #(.SIZE(S8), .I_BITS(8)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_c_full(bus),
        .o_busy(busy), .o_valid(valid), .i_ready(ready), .o_data(data),
        .o_row(row), .o_col(col), .o_last(last), .o_done(done),
        .o_start_drop(drop)
    );

    systolic_result_drain #(.SIZE(S4), .I_BITS(8)) dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_start(start4), .i_c_full(bus4),
        .o_busy(busy4), .o_valid(valid4), .i_ready(ready4), .o_data(data4),
        .o_row(row4), .o_col(col4), .o_last(last4), .o_done(done4),
        .o_start_drop(drop4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Ready pattern driver: 0 = always, 1 = 1,0,0,1,0 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        pcnt++;
        case (ready_mode)
            0: ready = 1'b1;
            1: ready = ((pcnt % 5) == 0) || ((pcnt % 5) == 3);
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (pending_done) begin
            check("done_after_last", done, 1);
            pending_done = 0;
        end else if (done) begin
            check("unexpected_done", done, 0);
        end
        if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        if (drop) drop_seen++;
        if (valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (held) begin
                check("hold_data", data, h_data);
                check("hold_rowcol", {row, col, last}, {h_row, h_col, h_last});
            end
            if (ready) begin
                held = 0;
                if (q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("data", data, e.data);
                    check("row", row, e.row);
                    check("col", col, e.col);
                    check("last", last, e.last);
                    hs_count++;
                    if (e.last) pending_done = 1;
                end
            end else begin
                held = 1;
                h_data = data; h_row = row; h_col = col; h_last = last;
            end
        end else begin
            held = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (pending4) begin
            check("done4", done4, 1);
            pending4 = 0;
        end
        if (done4) done4_seen = 1;
        if (valid4 && ready4) begin
            if (q4.size() == 0) begin
                check("extra_word4", 1, 0);
            end else begin
                e = q4.pop_front();
                check("data4", data4, e.data);
                check("rowcol4", {row4, col4}, {2'(e.row), 2'(e.col)});
                check("last4", last4, e.last);
                hs4++;
                if (e.last) pending4 = 1;
            end
        end
    end

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < N8; k++) begin
            e.data = exp_vals[k];
            e.row  = k / S8;
            e.col  = k % S8;
            e.last = (k == N8 - 1);
            q.push_back(e);
        end
    endtask

    task automatic set_bus_lin(input int base, input int mult);
        for (int k = 0; k < N8; k++) bus[OB8*k +: OB8] = OB8'(base + mult * k);
    endtask

    task automatic set_bus_rand();
        for (int k = 0; k < N8; k++) bus[OB8*k +: OB8] = OB8'($urandom);
    endtask

    task automatic do_start(output int t0);
        done_seen = 0;
        first_valid_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
        #1;
        if (!done_seen) check({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 3000 && hs_count < target; i++) begin
            @(negedge clk); #2;
        end
        if (hs_count < target) check("hs_wait_timeout", hs_count, target);
    endtask

    initial begin
        int t0, base;
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; bus = '0;
        start4 = 1'b0; ready4 = 1'b1; bus4 = '0;
        #12;
        check("reset_outputs", {busy, valid, data, row, col, last, done, drop}, 0);
        check("reset_outputs4", {busy4, valid4, data4, last4, done4, drop4}, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic stream, data appears mid-WAIT
        ready_mode = 0;
        set_bus_rand();
        for (int k = 0; k < N8; k++) exp_vals[k] = OB8'(3 * k);
        push_expected();
        base = hs_count;
        do_start(t0);
        repeat (9) @(posedge clk);
        #1; set_bus_lin(0, 3);
        wait_done("basic");
        check("basic_first_valid_cyc", first_valid_cyc, t0 + CC8);
        check("basic_done_cyc", done_cyc, t0 + CC8 + N8);
        check("basic_count", hs_count - base, N8);

        // 2: capture timing, change right after / right before the capture edge
        for (int v = 0; v < 2; v++) begin
            set_bus_lin(100, 1);
            for (int k = 0; k < N8; k++) exp_vals[k] = OB8'((v == 0 ? 100 : 500) + k);
            push_expected();
            do_start(t0);
            repeat (CC8 - v) @(posedge clk);
            #1; set_bus_lin(500, 1);
            wait_done("capture");
        end

        // 3: backpressure
        ready_mode = 1;
        set_bus_lin(7, 5);
        for (int k = 0; k < N8; k++) exp_vals[k] = OB8'(7 + 5 * k);
        push_expected();
        base = hs_count;
        do_start(t0);
        wait_done("backpressure");
        check("bp_count", hs_count - base, N8);
        check("bp_queue_empty", q.size(), 0);

        // 4: starts while busy (SEND word 10, then DONE cycle)
        ready_mode = 0;
        set_bus_lin(0, 1);
        for (int k = 0; k < N8; k++) exp_vals[k] = OB8'(k);
        push_expected();
        base = hs_count;
        do_start(t0);
        wait_hs(base + 10);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        exp_drops++;
        for (int i = 0; i < 200 && cyc < t0 + CC8 + N8; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        exp_drops++;
        wait_done("start_busy");
        repeat (2) @(posedge clk);
        #1;
        check("sb_idle_after", {busy, valid}, 0);
        check("sb_count", hs_count - base, N8);
        check("drop_pulses", drop_seen, exp_drops);

        // 5: async reset mid-SEND, then a clean full stream
        set_bus_rand();
        for (int k = 0; k < N8; k++) exp_vals[k] = bus[OB8*k +: OB8];
        push_expected();
        base = hs_count;
        do_start(t0);
        wait_hs(base + 20);
        rst_n = 1'b0;
        #1;
        check("reset_mid_valid_busy", {valid, busy}, 0);
        q.delete();
        pending_done = 0;
        held = 0;
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", done_seen, 0);
        set_bus_lin(1000, 2);
        for (int k = 0; k < N8; k++) exp_vals[k] = OB8'(1000 + 2 * k);
        push_expected();
        base = hs_count;
        do_start(t0);
        wait_done("after_reset");
        check("after_reset_count", hs_count - base, N8);

        // Randomized transfers: random data, random ready, bus scrambled after capture
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            set_bus_rand();
            for (int k = 0; k < N8; k++) exp_vals[k] = bus[OB8*k +: OB8];
            push_expected();
            base = hs_count;
            do_start(t0);
            repeat (CC8) @(posedge clk);
            #1; set_bus_rand();
            wait_done("random");
            check("random_count", hs_count - base, N8);
        end

        // 6: max values at SIZE=8 and SIZE=4
        ready_mode = 0;
        bus = '1;
        for (int k = 0; k < N8; k++) exp_vals[k] = 19'h7FFFF;
        push_expected();
        do_start(t0);
        wait_done("max8");

        bus4 = '1;
        for (int k = 0; k < N4; k++) begin
            exp_t e;
            e.data = 18'h3FFFF;
            e.row  = k / S4;
            e.col  = k % S4;
            e.last = (k == N4 - 1);
            q4.push_back(e);
        end
        start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        for (int i = 0; i < 500 && !done4_seen; i++) @(posedge clk);
        #1;
        check("max4_done", done4_seen, 1);
        check("max4_count", hs4, N4);
        check("max4_no_drop", drop4, 0);

        repeat (3) @(posedge clk);
        check("final_queue_empty", q.size(), 0);
        check("final_drop_total", drop_seen, exp_drops);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
